alu_fifo_ctrl: RTL and testbench

Frame sequencer between the UART receive FIFO, the ALU and the UART transmit FIFO. Pops three consecutive bytes from the RX FIFO (operand A, operand B, opcode), holds them on the ALU inputs, captures the combinational ALU result, and pushes it into the TX FIFO. Abandons partial frames after a configurable idle timeout.

---
 rtl/alu_fifo_ctrl_if.sv | 27 ++
 rtl/alu_fifo_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_fifo_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_fifo_ctrl_if.sv
// Bundle between the frame sequencer and its RX FIFO, ALU and TX FIFO.
// The sequencer takes the master side; the FIFOs and ALU sit on the slave side.
interface alu_fifo_ctrl_if #(
    parameter int B    = 8,
    parameter int OP_W = 6
);
    logic            rx_empty;
    logic [B-1:0]    rx_data;
    logic            rx_rd;
    logic            tx_full;
    logic            tx_wr;
    logic [B-1:0]    tx_data;
    logic [B-1:0]    alu_a;
    logic [B-1:0]    alu_b;
    logic [OP_W-1:0] alu_op;
    logic [B-1:0]    alu_result;

    modport master (
        input  rx_empty, rx_data, tx_full, alu_result,
        output rx_rd, tx_wr, tx_data, alu_a, alu_b, alu_op
    );

    modport slave (
        output rx_empty, rx_data, tx_full, alu_result,
        input  rx_rd, tx_wr, tx_data, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_fifo_ctrl.sv
// Frame sequencer: pops A, B, opcode from the RX FIFO, runs the external ALU and
// pushes the result to the TX FIFO; partial frames are dropped after an idle timeout.
//
// state    | meaning
// ---------+---------------------------------------------------------
// GET_A    | idle, waiting for operand A (never times out)
// GET_B    | waiting for operand B, idle counter running
// GET_OP   | waiting for opcode byte, idle counter running
// EXEC     | ALU inputs stable, capture combinational result
// SEND     | push result to TX FIFO, stall while it is full
module alu_fifo_ctrl #(
    parameter int B       = 8,
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 1000,
    parameter int FCNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    alu_fifo_ctrl_if.master   bus,
    output logic              busy,
    output logic              frame_err,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        EXEC,
        SEND
    } state_t;

    state_t            state_q, state_d;
    logic [B-1:0]      a_q, a_d;
    logic [B-1:0]      b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [B-1:0]      res_q, res_d;
    logic [FCNT_W-1:0] cnt_q, cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              err_q, err_d;
    logic              rx_rd_c;
    logic              tx_wr_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        err_d   = 1'b0;
        rx_rd_c = 1'b0;
        tx_wr_c = 1'b0;

        case (state_q)
            GET_A: begin
                idle_d = '0;
                if (!bus.rx_empty) begin
                    rx_rd_c = 1'b1;
                    a_d     = bus.rx_data;
                    state_d = GET_B;
                end
            end

            // A byte arriving in the terminal idle cycle takes priority over the timeout.
            GET_B: begin
                if (!bus.rx_empty) begin
                    rx_rd_c = 1'b1;
                    b_d     = bus.rx_data;
                    idle_d  = '0;
                    state_d = GET_OP;
                end else if (idle_q == IDLE_LAST) begin
                    idle_d  = '0;
                    err_d   = 1'b1;
                    state_d = GET_A;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end

            GET_OP: begin
                if (!bus.rx_empty) begin
                    rx_rd_c = 1'b1;
                    op_d    = bus.rx_data[OP_W-1:0];
                    idle_d  = '0;
                    state_d = EXEC;
                end else if (idle_q == IDLE_LAST) begin
                    idle_d  = '0;
                    err_d   = 1'b1;
                    state_d = GET_A;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end

            EXEC: begin
                res_d   = bus.alu_result;
                state_d = SEND;
            end

            SEND: begin
                if (!bus.tx_full) begin
                    tx_wr_c = 1'b1;
                    cnt_d   = cnt_q + FCNT_W'(1);
                    state_d = GET_A;
                end
            end

            default: state_d = GET_A;
        endcase
    end

    // Strobes are decoded from state, so gate them while the state register is being reset.
    assign bus.rx_rd   = rx_rd_c & ~reset;
    assign bus.tx_wr   = tx_wr_c & ~reset;
    assign bus.tx_data = res_q;
    assign bus.alu_a   = a_q;
    assign bus.alu_b   = b_q;
    assign bus.alu_op  = op_q;

    assign busy      = (state_q != GET_A);
    assign frame_err = err_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_alu_fifo_ctrl.sv
// Directed bench for alu_fifo_ctrl: RX FIFO model, ALU model and event logs sampled
// on the falling edge; each scenario checks logged cycles and values against hand results.
module tb_alu_fifo_ctrl;

    localparam int B       = 8;
    localparam int OP_W    = 6;
    localparam int TIMEOUT = 4;
    localparam int FCNT_W  = 2;

    logic              clk;
    logic              reset;
    logic              busy;
    logic              frame_err;
    logic [FCNT_W-1:0] frame_cnt;

    alu_fifo_ctrl_if #(.B(B), .OP_W(OP_W)) bus ();

    alu_fifo_ctrl #(
        .B(B), .OP_W(OP_W), .TIMEOUT(TIMEOUT), .FCNT_W(FCNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h21:   return a - b;
            6'h22:   return a & b;
            6'h23:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

    // Fall-through RX FIFO
    logic [7:0] rx_mem [0:255];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    assign bus.rx_empty = (wr_ptr == rd_ptr);
    assign bus.rx_data  = rx_mem[rd_ptr];

    initial rd_ptr = 8'd0;
    always @(posedge clk) if (bus.rx_rd) rd_ptr <= rd_ptr + 8'd1;

    task automatic push(input logic [7:0] d);
        rx_mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // Event logs
    int         cyc;
    int         rd_n, tx_n, err_n;
    int         rd_cyc  [0:255];
    int         tx_cyc  [0:255];
    logic [7:0] tx_dat  [0:255];
    int         fc_log  [0:255];
    int         err_cyc [0:255];
    logic       pend;

    initial begin
        cyc = 0; rd_n = 0; tx_n = 0; err_n = 0; pend = 1'b0;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (pend) begin
            fc_log[tx_n-1] = int'(frame_cnt);
            pend = 1'b0;
        end
        if (bus.rx_rd) begin
            rd_cyc[rd_n] = cyc;
            rd_n = rd_n + 1;
        end
        if (bus.tx_wr) begin
            tx_cyc[tx_n] = cyc;
            tx_dat[tx_n] = bus.tx_data;
            tx_n = tx_n + 1;
            pend = 1'b1;
        end
        if (frame_err) begin
            err_cyc[err_n] = cyc;
            err_n = err_n + 1;
        end
    end

    int checks;
    int failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    int         rb, tb0, eb, rel;
    logic [7:0] wa [0:4];
    logic [7:0] wb [0:4];
    logic [7:0] wo [0:4];
    int         exp_fc [0:4];

    initial begin
        checks = 0; failures = 0;
        exp_fc = '{1, 2, 3, 0, 1};
        wr_ptr = 8'd0;
        bus.tx_full = 1'b0;
        reset = 1'b1;

        // Reset state
        tick(3);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_rx_rd",     32'(bus.rx_rd), 0);
        chk("rst_tx_wr",     32'(bus.tx_wr), 0);
        chk("rst_tx_data",   32'(bus.tx_data), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_alu_a",     32'(bus.alu_a), 0);
        reset = 1'b0;

        // Basic frame 5 + 3
        rb = rd_n; tb0 = tx_n;
        push(8'h05); push(8'h03); push(8'h20);
        tick(8);
        chk("basic_rd_count", 32'(rd_n - rb), 3);
        chk("basic_rd_b_gap", 32'(rd_cyc[rb+1] - rd_cyc[rb]), 1);
        chk("basic_rd_op_gap", 32'(rd_cyc[rb+2] - rd_cyc[rb+1]), 1);
        chk("basic_alu_a",    32'(bus.alu_a), 32'h05);
        chk("basic_alu_b",    32'(bus.alu_b), 32'h03);
        chk("basic_alu_op",   32'(bus.alu_op), 32'h20);
        chk("basic_tx_count", 32'(tx_n - tb0), 1);
        chk("basic_tx_lat",   32'(tx_cyc[tb0] - rd_cyc[rb+2]), 2);
        chk("basic_tx_data",  32'(tx_dat[tb0]), 32'h08);
        chk("basic_frame_cnt", 32'(frame_cnt), 1);

        // Back-pressure: two queued frames, TX full during the first SEND
        do_reset();
        rb = rd_n; tb0 = tx_n;
        bus.tx_full = 1'b1;
        push(8'h10); push(8'h07); push(8'h21);
        push(8'hF0); push(8'h0F); push(8'hE3);
        tick(14);
        chk("bp_no_push",   32'(tx_n - tb0), 0);
        chk("bp_no_pop",    32'(rd_n - rb), 3);
        chk("bp_busy",      32'(busy), 1);
        chk("bp_tx_wr_low", 32'(bus.tx_wr), 0);
        chk("bp_rx_rd_low", 32'(bus.rx_rd), 0);
        bus.tx_full = 1'b0;
        rel = cyc + 1;
        #1;
        chk("bp_tx_wr_release", 32'(bus.tx_wr), 1);
        tick(10);
        chk("bp_tx_count",   32'(tx_n - tb0), 2);
        chk("bp_tx_cycle",   32'(tx_cyc[tb0]), 32'(rel));
        chk("bp_tx_data0",   32'(tx_dat[tb0]), 32'h09);
        chk("bp_next_a_pop", 32'(rd_cyc[rb+3]), 32'(rel + 1));
        chk("bp_alu_op_mask", 32'(bus.alu_op), 32'h23);
        chk("bp_tx_data1",   32'(tx_dat[tb0+1]), 32'hFF);
        chk("bp_frame_cnt",  32'(frame_cnt), 2);

        // Timeout in GET_OP: four empty cycles after the B pop, error on the next one
        do_reset();
        rb = rd_n; tb0 = tx_n; eb = err_n;
        push(8'h11); push(8'h22);
        tick(12);
        chk("to_err_count", 32'(err_n - eb), 1);
        chk("to_err_cycle", 32'(err_cyc[eb] - rd_cyc[rb+1]), 5);
        chk("to_busy",      32'(busy), 0);
        chk("to_keep_a",    32'(bus.alu_a), 32'h11);
        chk("to_keep_b",    32'(bus.alu_b), 32'h22);
        chk("to_frame_cnt", 32'(frame_cnt), 0);
        push(8'h01); push(8'h01); push(8'h20);
        tick(8);
        chk("to_next_tx_count", 32'(tx_n - tb0), 1);
        chk("to_next_tx_data",  32'(tx_dat[tb0]), 32'h02);
        chk("to_next_frame_cnt", 32'(frame_cnt), 1);
        chk("to_next_no_err",   32'(err_n - eb), 1);
        // Timeout in GET_B
        push(8'h99);
        tick(10);
        chk("tob_err_count", 32'(err_n - eb), 2);
        chk("tob_err_cycle", 32'(err_cyc[eb+1] - rd_cyc[rb+5]), 5);
        chk("tob_frame_cnt", 32'(frame_cnt), 1);

        // Late byte on the last allowed idle cycle
        do_reset();
        rb = rd_n; tb0 = tx_n; eb = err_n;
        push(8'h30); push(8'h04);
        tick(5);
        push(8'h20);
        tick(8);
        chk("late_op_gap",   32'(rd_cyc[rb+2] - rd_cyc[rb+1]), 4);
        chk("late_no_err",   32'(err_n - eb), 0);
        chk("late_tx_count", 32'(tx_n - tb0), 1);
        chk("late_tx_data",  32'(tx_dat[tb0]), 32'h34);
        chk("late_frame_cnt", 32'(frame_cnt), 1);

        // Reset while in GET_OP, fresh frame already waiting in the FIFO
        do_reset();
        rb = rd_n; tb0 = tx_n; eb = err_n;
        push(8'h44); push(8'h55);
        tick(3);
        reset = 1'b1;
        push(8'h06); push(8'h07); push(8'h21);
        #1;
        chk("mr_rx_rd_forced", 32'(bus.rx_rd), 0);
        tick(1);
        chk("mr_busy",      32'(busy), 0);
        chk("mr_frame_err", 32'(frame_err), 0);
        chk("mr_alu_a",     32'(bus.alu_a), 0);
        chk("mr_alu_b",     32'(bus.alu_b), 0);
        chk("mr_alu_op",    32'(bus.alu_op), 0);
        chk("mr_tx_data",   32'(bus.tx_data), 0);
        chk("mr_tx_wr",     32'(bus.tx_wr), 0);
        chk("mr_rx_rd",     32'(bus.rx_rd), 0);
        reset = 1'b0;
        tick(8);
        chk("mr_new_a",     32'(bus.alu_a), 32'h06);
        chk("mr_new_b",     32'(bus.alu_b), 32'h07);
        chk("mr_new_op",    32'(bus.alu_op), 32'h21);
        chk("mr_tx_count",  32'(tx_n - tb0), 1);
        chk("mr_tx_value",  32'(tx_dat[tb0]), 32'hFF);
        chk("mr_frame_cnt", 32'(frame_cnt), 1);
        chk("mr_no_err",    32'(err_n - eb), 0);

        // Counter wrap with five back-to-back random frames
        do_reset();
        rb = rd_n; tb0 = tx_n;
        for (int i = 0; i < 5; i++) begin
            wa[i] = 8'($urandom);
            wb[i] = 8'($urandom);
            wo[i] = {2'($urandom_range(0, 3)), 6'h20 + 6'($urandom_range(0, 3))};
            push(wa[i]); push(wb[i]); push(wo[i]);
        end
        tick(35);
        chk("wrap_tx_count", 32'(tx_n - tb0), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("wrap_tx_data%0d", i), 32'(tx_dat[tb0+i]),
                32'(alu_model(wa[i], wb[i], wo[i][5:0])));
            chk($sformatf("wrap_frame_cnt%0d", i), 32'(fc_log[tb0+i]), 32'(exp_fc[i]));
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_period%0d", i), 32'(rd_cyc[rb+3*(i+1)] - rd_cyc[rb+3*i]), 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
